// File: rtl/tqvp_rejunity_vga_capture.sv
// VGA input capture peripheral for TinyQV: measures sync timing and captures one
// selected line as 256 one-bit pixels, laid out like the VGA output video memory.
module tqvp_rejunity_vga_capture #(
   parameter int HCNT_W = 12,
   parameter int VCNT_W = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  ui_in,
   output logic [7:0]  uo_out,
   input  logic [5:0]  address,
   input  logic [31:0] data_in,
   input  logic [1:0]  data_write_n,
   input  logic [1:0]  data_read_n,
   output logic [31:0] data_out,
   output logic        data_ready,
   output logic        user_interrupt
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_WAIT_FRAME = 3'd1;
   localparam logic [2:0] S_WAIT_LINE  = 3'd2;
   localparam logic [2:0] S_DELAY      = 3'd3;
   localparam logic [2:0] S_SAMPLE     = 3'd4;

   localparam logic [HCNT_W-1:0] HMAX = '1;
   localparam logic [VCNT_W-1:0] VMAX = '1;

   logic [2:0]        state;
   logic              done;
   logic              short_flag;
   logic              locked;
   logic              hs_pol;
   logic              vs_pol;
   logic [VCNT_W-1:0] cap_line;
   logic [HCNT_W-1:0] h_start;
   logic [7:0]        h_step;
   logic [5:0]        match_col;
   logic [5:0]        match_mask;
   logic [HCNT_W-1:0] hcnt;
   logic [HCNT_W-1:0] hperiod;
   logic [HCNT_W-1:0] hwidth;
   logic [VCNT_W-1:0] lcnt;
   logic [VCNT_W-1:0] vlines;
   logic [VCNT_W-1:0] vw_cnt;
   logic [VCNT_W-1:0] vwidth;
   logic [VCNT_W-1:0] aln;
   logic [HCNT_W-1:0] dcnt;
   logic [7:0]        scnt;
   logic [7:0]        idx;
   logic [255:0]      cap_buf;

   logic              hs, vs, hs_d, vs_d;
   logic              h_le, h_te, v_le, v_te;
   logic [HCNT_W-1:0] hcnt_inc;
   logic [VCNT_W-1:0] lcnt_inc, vw_inc, aln_inc;
   logic [5:0]        rrggbb;
   logic              pixel;
   logic              write_en;
   logic [3:0]        reg_sel;
   logic              ctrl_wr;
   logic              armed;
   logic              unused_bits;

   // hs/vs are 1 while the sync pulse is active, whatever the wire polarity
   assign hs   = ui_in[7] ~^ hs_pol;
   assign vs   = ui_in[3] ~^ vs_pol;
   assign h_le = hs & ~hs_d;
   assign h_te = ~hs & hs_d;
   assign v_le = vs & ~vs_d;
   assign v_te = ~vs & vs_d;

   assign hcnt_inc = (hcnt == HMAX)   ? HMAX : hcnt + HCNT_W'(1);
   assign lcnt_inc = (lcnt == VMAX)   ? VMAX : lcnt + VCNT_W'(1);
   assign vw_inc   = (vw_cnt == VMAX) ? VMAX : vw_cnt + VCNT_W'(1);
   assign aln_inc  = (aln == VMAX)    ? VMAX : aln + VCNT_W'(1);

   assign rrggbb = {ui_in[6:4], ui_in[2:0]};
   assign pixel  = ((rrggbb ^ match_col) & match_mask) == 6'd0;

   assign write_en = (data_write_n != 2'b11);
   assign reg_sel  = address[5:2];
   assign ctrl_wr  = write_en && (reg_sel == 4'h8);
   assign armed    = (state != S_IDLE);

   assign uo_out         = 8'd0;
   assign data_ready     = 1'b1;
   assign user_interrupt = done;
   assign unused_bits    = &{1'b0, data_read_n, address[1:0], data_in[31:14]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hs_d    <= 1'b0;
         vs_d    <= 1'b0;
         hcnt    <= '0;
         hperiod <= '0;
         hwidth  <= '0;
         locked  <= 1'b0;
      end else begin
         hs_d <= hs;
         vs_d <= vs;
         if (h_le) begin
            hperiod <= hcnt_inc;
            locked  <= (hcnt_inc == hperiod) && (hcnt_inc != HMAX);
            hcnt    <= '0;
         end else begin
            hcnt <= hcnt_inc;
         end
         if (h_te) hwidth <= hcnt_inc;
      end
   end

   // A line starting in the same cycle as vsync counts towards the new frame
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lcnt   <= '0;
         vlines <= '0;
         vw_cnt <= '0;
         vwidth <= '0;
         aln    <= '0;
      end else begin
         if (v_le) begin
            vlines <= lcnt;
            lcnt   <= VCNT_W'(h_le);
            vw_cnt <= VCNT_W'(h_le);
         end else if (h_le) begin
            lcnt <= lcnt_inc;
            if (vs) vw_cnt <= vw_inc;
         end
         if (v_te) begin
            vwidth <= vw_cnt;
            aln    <= '0;
         end else if (h_le) begin
            aln <= aln_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cap_line   <= '0;
         h_start    <= '0;
         h_step     <= '0;
         match_col  <= '0;
         match_mask <= '0;
         hs_pol     <= 1'b0;
         vs_pol     <= 1'b0;
      end else if (write_en) begin
         case (reg_sel)
            4'h8: begin
               hs_pol <= data_in[1];
               vs_pol <= data_in[2];
            end
            4'h9: cap_line <= data_in[VCNT_W-1:0];
            4'hA: h_start  <= data_in[HCNT_W-1:0];
            4'hB: h_step   <= data_in[7:0];
            4'hC: begin
               match_col  <= data_in[5:0];
               match_mask <= data_in[13:8];
            end
            default: ;
         endcase
      end
   end

   // CPU writes to CTRL take priority over any progress of the capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         done       <= 1'b0;
         short_flag <= 1'b0;
         dcnt       <= '0;
         scnt       <= '0;
         idx        <= '0;
         cap_buf    <= '0;
      end else if (ctrl_wr) begin
         if (data_in[0]) begin
            state      <= S_WAIT_FRAME;
            done       <= 1'b0;
            short_flag <= 1'b0;
         end else begin
            state <= S_IDLE;
         end
      end else begin
         case (state)
            S_WAIT_FRAME: if (v_te) state <= S_WAIT_LINE;
            S_WAIT_LINE: begin
               if (h_te && (aln == cap_line)) begin
                  dcnt  <= h_start;
                  idx   <= '0;
                  scnt  <= '0;
                  state <= (h_start == '0) ? S_SAMPLE : S_DELAY;
               end
            end
            S_DELAY: begin
               dcnt <= dcnt - HCNT_W'(1);
               if (dcnt == HCNT_W'(1)) state <= S_SAMPLE;
            end
            S_SAMPLE: begin
               if (h_le) begin
                  short_flag <= 1'b1;
                  done       <= 1'b1;
                  state      <= S_IDLE;
               end else if (scnt == 8'd0) begin
                  cap_buf[idx] <= pixel;
                  scnt         <= h_step;
                  if (idx == 8'hFF) begin
                     done  <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     idx <= idx + 8'd1;
                  end
               end else begin
                  scnt <= scnt - 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      data_out = '0;
      if (!address[5]) begin
         data_out = cap_buf[{address[4:2], 5'b00000} +: 32];
      end else begin
         case (address[4:2])
            3'd0: data_out = {25'd0, state, short_flag, locked, done, armed};
            3'd1: data_out[VCNT_W-1:0] = cap_line;
            3'd2: data_out[HCNT_W-1:0] = h_start;
            3'd3: data_out[7:0] = h_step;
            3'd4: data_out = {18'd0, match_mask, 2'd0, match_col};
            3'd5: data_out[HCNT_W-1:0] = hperiod;
            3'd6: data_out[HCNT_W-1:0] = hwidth;
            default: begin
               data_out[VCNT_W-1:0]  = vlines;
               data_out[16 +: VCNT_W] = vwidth;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tqvp_rejunity_vga_capture.sv
// Directed bench for the VGA capture peripheral: synthetic sync timing, line
// capture (full, short, aborted), counter saturation, polarity and reset.
module tb_tqvp_rejunity_vga_capture;

   logic        clk;
   logic        rst_n;
   logic [7:0]  ui_in;
   logic [7:0]  uo_out;
   logic [5:0]  address;
   logic [31:0] data_in;
   logic [1:0]  data_write_n;
   logic [1:0]  data_read_n;
   logic [31:0] data_out;
   logic        data_ready;
   logic        user_interrupt;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [5:0] A_CTRL = 6'h20, A_CAP = 6'h24, A_HST = 6'h28, A_STEP = 6'h2C;
   localparam logic [5:0] A_MATCH = 6'h30, A_HPER = 6'h34, A_HWID = 6'h38, A_VINFO = 6'h3C;

   tqvp_rejunity_vga_capture dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ui_in          (ui_in),
      .uo_out         (uo_out),
      .address        (address),
      .data_in        (data_in),
      .data_write_n   (data_write_n),
      .data_read_n    (data_read_n),
      .data_out       (data_out),
      .data_ready     (data_ready),
      .user_interrupt (user_interrupt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
      @(negedge clk);
      address      = a;
      data_in      = d;
      data_write_n = 2'b10;
      @(negedge clk);
      data_write_n = 2'b11;
   endtask

   // Reads without consuming a clock, so line timing is not disturbed
   task automatic read_now(input logic [5:0] a, output logic [31:0] d);
      address     = a;
      data_read_n = 2'b10;
      #1;
      d           = data_out;
      data_read_n = 2'b11;
   endtask

   task automatic check_now(input string tag, input logic [5:0] a, input logic [31:0] exp);
      logic [31:0] v;
      read_now(a, v);
      check(tag, v, exp);
   endtask

   task automatic check_reg(input string tag, input logic [5:0] a, input logic [31:0] exp);
      @(negedge clk);
      check_now(tag, a, exp);
   endtask

   // 20-line frame, vsync active-low for lines 0-1, hsync pulse of hw clocks at
   // each line start; on row cap_row, clocks lo_c..hi_c carry col_on.
   task automatic run_frame(input int len, input int hw, input logic hs_high,
                            input int cap_row, input int lo_c, input int hi_c,
                            input logic [5:0] col_on, input logic [5:0] col_off,
                            input int stop_line, input int stop_c);
      logic [5:0] px;
      logic       hs_act;
      logic       vs_act;
      logic       raw_h;
      for (int l = 0; l < 20; l++) begin
         for (int c = 0; c < len; c++) begin
            hs_act = (c < hw);
            vs_act = (l < 2);
            raw_h  = hs_high ? hs_act : ~hs_act;
            px     = (l == cap_row && c >= lo_c && c <= hi_c) ? col_on : col_off;
            @(negedge clk);
            ui_in = {raw_h, px[5:3], ~vs_act, px[2:0]};
            if (l == stop_line && c == stop_c) return;
         end
      end
      @(negedge clk);
      ui_in = {~hs_high, 3'b000, 1'b1, 3'b000};
   endtask

   task automatic run_lines(input int n, input int len, input int hw, input logic hs_high);
      logic hs_act;
      for (int l = 0; l < n; l++) begin
         for (int c = 0; c < len; c++) begin
            hs_act = (c < hw);
            @(negedge clk);
            ui_in = {(hs_high ? hs_act : ~hs_act), 3'b000, 1'b1, 3'b000};
         end
      end
   endtask

   initial begin
      logic [31:0] v;
      rst_n        = 1'b0;
      ui_in        = 8'h88;
      address      = 6'h00;
      data_in      = 32'h0;
      data_write_n = 2'b11;
      data_read_n  = 2'b11;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      check("reset_ctrl", 32'(dut.data_out & 32'h0) | 32'h0, 32'h0);
      check_reg("reset_ctrl_reg", A_CTRL, 32'h0);
      check_reg("reset_cap_line", A_CAP, 32'h0);
      check_reg("reset_h_start", A_HST, 32'h0);
      check_reg("reset_h_step", A_STEP, 32'h0);
      check_reg("reset_match", A_MATCH, 32'h0);
      check_reg("reset_hperiod", A_HPER, 32'h0);
      check_reg("reset_hwidth", A_HWID, 32'h0);
      check_reg("reset_vinfo", A_VINFO, 32'h0);
      check_reg("reset_buf0", 6'h00, 32'h0);
      check_reg("reset_buf7", 6'h1C, 32'h0);
      check("reset_uo_out", {24'h0, uo_out}, 32'h0);
      check("reset_data_ready", {31'h0, data_ready}, 32'h1);
      check("reset_irq", {31'h0, user_interrupt}, 32'h0);

      // Two frames of 100-clock lines, 12-clock hsync, 2-line vsync
      run_frame(100, 12, 1'b0, -1, 0, 0, 6'h00, 6'h00, -1, -1);
      run_frame(100, 12, 1'b0, -1, 0, 0, 6'h00, 6'h00, -1, -1);
      check_reg("timing_hperiod", A_HPER, 32'd100);
      check_reg("timing_hwidth", A_HWID, 32'd12);
      check_reg("timing_vinfo", A_VINFO, 32'h0002_0014);
      check_reg("timing_locked", A_CTRL, 32'h4);

      // Capture on 320-clock lines; aln 3 is frame line 5 (vsync ends at line 2).
      // Sample i is taken at clock 12+1+H_START+i = 33+i of that line.
      bus_write(A_CAP, 32'd3);
      bus_write(A_HST, 32'd20);
      bus_write(A_STEP, 32'd0);
      bus_write(A_MATCH, 32'h0000_3F0B);
      check_reg("match_readback", A_MATCH, 32'h0000_3F0B);
      bus_write(A_CTRL, 32'h1);
      check_reg("armed_wait_frame", A_CTRL, 32'h15);
      run_frame(320, 12, 1'b0, 5, 38, 73, 6'h0B, 6'h10, -1, -1);
      check_reg("cap_ctrl", A_CTRL, 32'h6);
      check("cap_irq", {31'h0, user_interrupt}, 32'h1);
      check_reg("cap_buf0", 6'h00, 32'hFFFF_FFE0);
      check_reg("cap_buf1", 6'h04, 32'h0000_01FF);
      check_reg("cap_buf2", 6'h08, 32'h0);
      check_reg("cap_buf7", 6'h1C, 32'h0);
      check_reg("cap_hperiod", A_HPER, 32'd320);

      // Fill the buffer with ones, then a short 100-clock line writes only 67 zeros
      bus_write(A_CTRL, 32'h1);
      check("rearm_irq_clear", {31'h0, user_interrupt}, 32'h0);
      run_frame(320, 12, 1'b0, 5, 0, 1000, 6'h0B, 6'h10, -1, -1);
      check_reg("fill_buf3", 6'h0C, 32'hFFFF_FFFF);
      check_reg("fill_buf7", 6'h1C, 32'hFFFF_FFFF);
      bus_write(A_CTRL, 32'h1);
      run_frame(100, 12, 1'b0, 5, 1000, 0, 6'h0B, 6'h10, -1, -1);
      check_reg("short_ctrl", A_CTRL, 32'hE);
      check("short_irq", {31'h0, user_interrupt}, 32'h1);
      check_reg("short_buf0", 6'h00, 32'h0);
      check_reg("short_buf1", 6'h04, 32'h0);
      check_reg("short_buf2", 6'h08, 32'hFFFF_FFF8);
      check_reg("short_buf3", 6'h0C, 32'hFFFF_FFFF);
      check_reg("short_buf7", 6'h1C, 32'hFFFF_FFFF);

      // Abort during WAIT_LINE
      bus_write(A_CAP, 32'd100);
      bus_write(A_CTRL, 32'h1);
      run_frame(100, 12, 1'b0, -1, 0, 0, 6'h00, 6'h00, -1, -1);
      check_reg("abort_wait_line", A_CTRL, 32'h25);
      bus_write(A_CTRL, 32'h0);
      check_reg("abort_idle", A_CTRL, 32'h4);
      bus_write(A_CAP, 32'd3);
      for (int f = 0; f < 3; f++)
         run_frame(100, 12, 1'b0, 5, 0, 1000, 6'h0B, 6'h10, -1, -1);
      check_reg("abort_stays_idle", A_CTRL, 32'h4);
      check("abort_no_irq", {31'h0, user_interrupt}, 32'h0);

      // Saturation: no hsync edge for 5000 clocks, then 100-clock lines again
      repeat (5000) @(negedge clk);
      run_lines(1, 100, 12, 1'b0);
      check_now("sat_hperiod", A_HPER, 32'h0000_0FFF);
      check_now("sat_unlocked", A_CTRL, 32'h0);
      run_lines(1, 100, 12, 1'b0);
      check_now("relock_hperiod", A_HPER, 32'd100);
      check_now("relock_one_edge", A_CTRL, 32'h0);
      run_lines(1, 100, 12, 1'b0);
      check_now("relock_two_edges", A_CTRL, 32'h4);

      // Active-high hsync
      bus_write(A_CTRL, 32'h2);
      run_lines(3, 100, 12, 1'b1);
      check_reg("pol_hwidth", A_HWID, 32'd12);
      check_reg("pol_hperiod", A_HPER, 32'd100);

      // Reset in the middle of SAMPLE
      bus_write(A_HST, 32'd0);
      bus_write(A_CTRL, 32'h3);
      run_frame(100, 12, 1'b1, -1, 0, 0, 6'h00, 6'h00, 5, 40);
      read_now(A_CTRL, v);
      check("mid_sample_state", v & 32'h71, 32'h41);
      ui_in = 8'h88;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_now("rst_ctrl", A_CTRL, 32'h0);
      check_reg("rst_cap_line", A_CAP, 32'h0);
      check_reg("rst_match", A_MATCH, 32'h0);
      check_reg("rst_hperiod", A_HPER, 32'h0);
      check_reg("rst_hwidth", A_HWID, 32'h0);
      check_reg("rst_vinfo", A_VINFO, 32'h0);
      check_reg("rst_buf0", 6'h00, 32'h0);
      check_reg("rst_buf3", 6'h0C, 32'h0);
      check("rst_irq", {31'h0, user_interrupt}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
